bandpass_decim: RTL

- Receive-side counterpart of the interpolating bandpass chain: accepts a full-rate signed sample stream and applies the same comb bandpass H(z) = 1 - 2z^-D + z^-2D.
- Decimates the filtered stream by M and presents it on a valid/ready output with saturation to W bits.
- Sits after the up-sampled/filtered path, returning data to the base sample rate for downstream consumers.

---
 rtl/bandpass_decim_pkg.sv | 35 +++
 rtl/bandpass_decim_delay.sv | 30 +++
 rtl/bandpass_decim.sv | 110 +++++++++++
 3 files changed

// File: rtl/bandpass_decim_pkg.sv
// bandpass_pkg: shared types, default constants and the output saturator
// for the bandpass decimator.
//   sample_t   - signed sample at the default width
//   acc_t      - signed comb accumulator, two guard bits wider than a sample
//   saturate() - clamps a signed value to a w-bit two's complement range and
//                reports whether it clipped
package bandpass_pkg;

  localparam int W_DEF = 8;
  localparam int D_DEF = 6;
  localparam int M_DEF = 2;

  typedef logic signed [W_DEF-1:0] sample_t;
  typedef logic signed [W_DEF+1:0] acc_t;

  // w is always a elaboration-time constant at the call site, so the bounds
  // reduce to constants. Callers size-cast the result down to w bits.
  function automatic logic signed [31:0] saturate(input logic signed [31:0] v,
                                                  input int w,
                                                  output logic clip);
    logic signed [31:0] hi, lo;
    hi = (32'sd1 <<< (w-1)) - 32'sd1;
    lo = -(32'sd1 <<< (w-1));
    clip     = 1'b0;
    saturate = v;
    if (v > hi) begin
      saturate = hi;
      clip     = 1'b1;
    end else if (v < lo) begin
      saturate = lo;
      clip     = 1'b1;
    end
  endfunction

endpackage

// File: rtl/bandpass_decim_delay.sv
// sample_delay_line: 2*D-deep sample shift register, advanced by en.
//   clk, reset   - clock, synchronous active-high clear
//   en           - shift x_i in (one accepted sample)
//   x_i          - newest sample
//   tap_d_o      - sample accepted D shifts ago
//   tap_2d_o     - sample accepted 2*D shifts ago
module sample_delay_line #(
  parameter int W = 8,
  parameter int D = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] x_i,
  output logic [W-1:0] tap_d_o,
  output logic [W-1:0] tap_2d_o
);

  // sr_q[k] holds the (k+1)-th previously accepted sample.
  logic [2*D-1:0][W-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (reset)   sr_q <= '0;
    else if (en) sr_q <= {sr_q[2*D-2:0], x_i};
  end

  assign tap_d_o  = sr_q[D-1];
  assign tap_2d_o = sr_q[2*D-1];

endmodule

// File: rtl/bandpass_decim.sv
// bandpass_decim: comb bandpass H(z) = 1 - 2z^-D + z^-2D on an accepted
// sample stream, decimated by M, saturated to W bits, valid/ready output.
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_ready     - input handshake, data_in signed sample
//   out_valid/out_ready   - output handshake, data_out signed sample
//   sat_flag              - sticky, set when a captured output clipped
// Optional: define BANDPASS_DECIM_SCALE_EN to divide the comb sum by 4
// (round half up) before saturation.
module bandpass_decim
  import bandpass_pkg::*;
#(
  parameter int W = W_DEF,
  parameter int D = D_DEF,
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] data_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] data_out,
  output logic         sat_flag
);

  localparam int PW = (M > 1) ? $clog2(M) : 1;
  localparam logic [PW-1:0] PH_LAST = PW'(M-1);

  logic              acc;
  logic              cap;
  logic [PW-1:0]     phase_q, phase_d;
  logic              out_valid_q, out_valid_d;
  logic [W-1:0]      data_q, data_d;
  logic              sat_q, sat_d;
  logic [W-1:0]      tap_d, tap_2d;
  logic signed [W+1:0] acc_sum;
  logic signed [W+2:0] pre_sat;
  logic [W-1:0]      sat_val;
  logic              clip;

  sample_delay_line #(.W(W), .D(D)) u_dly (
    .clk      (clk),
    .reset    (reset),
    .en       (acc),
    .x_i      (data_in),
    .tap_d_o  (tap_d),
    .tap_2d_o (tap_2d)
  );

  // Only the decimated phase can be blocked by a held, unconsumed output.
  assign in_ready = (phase_q != '0) || !out_valid_q || out_ready;
  assign acc      = in_valid && in_ready;
  assign cap      = acc && (phase_q == '0);

  // |x - 2x[n-D] + x[n-2D]| <= 4*2^(W-1) - 2, fits in W+2 bits.
  assign acc_sum = $signed({{2{data_in[W-1]}}, data_in})
                 - ($signed({{2{tap_d[W-1]}}, tap_d}) <<< 1)
                 + $signed({{2{tap_2d[W-1]}}, tap_2d});

`ifdef BANDPASS_DECIM_SCALE_EN
  // One extra bit so the rounding offset on the positive extreme cannot wrap.
  localparam logic signed [W+2:0] RND = (W+3)'(2);
  logic signed [W+2:0] rnd_sum;
  assign rnd_sum = $signed({acc_sum[W+1], acc_sum}) + RND;
  assign pre_sat = rnd_sum >>> 2;
`else
  assign pre_sat = $signed({acc_sum[W+1], acc_sum});
`endif

  always_comb begin
    clip    = 1'b0;
    sat_val = W'(saturate(32'(pre_sat), W, clip));
  end

  always_comb begin
    phase_d     = phase_q;
    out_valid_d = out_valid_q;
    data_d      = data_q;
    sat_d       = sat_q;
    if (acc) phase_d = (phase_q == PH_LAST) ? '0 : phase_q + PW'(1);
    // A capture wins over a drain in the same cycle; out_valid stays high.
    if (cap) begin
      data_d      = sat_val;
      out_valid_d = 1'b1;
      sat_d       = sat_q | clip;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q     <= '0;
      out_valid_q <= 1'b0;
      data_q      <= '0;
      sat_q       <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      out_valid_q <= out_valid_d;
      data_q      <= data_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign data_out  = data_q;
  assign sat_flag  = sat_q;

endmodule
